// File: rtl/memory_write_channel_scheduler_pkg.sv
// Shared types and default geometry for the AXI4 write-channel scheduler.
package memory_write_channel_scheduler_pkg;

  localparam int unsigned MWCS_ID_WIDTH   = 3;
  localparam int unsigned MWCS_ADDR_WIDTH = 32;
  localparam int unsigned MWCS_ENTRY_BITS = 128;
  localparam int unsigned MWCS_DATA_WIDTH = 32;
  localparam int unsigned BEAT_NUM        = MWCS_ENTRY_BITS / MWCS_DATA_WIDTH;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef logic [MWCS_ID_WIDTH-1:0] write_id_t;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_BURST   = 2'd1,
    W_WAIT_AW = 2'd2
  } w_beat_state_e;

endpackage

// File: rtl/memory_write_channel_scheduler_id_tracker.sv
// Per-ID outstanding B-response bitmap and registered completion pulse.
module memory_write_channel_scheduler_id_tracker
  import memory_write_channel_scheduler_pkg::*;
#(
  parameter int unsigned ID_WIDTH = MWCS_ID_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       set_i,
  input  logic [ID_WIDTH-1:0]        set_id_i,
  input  logic                       b_valid_i,
  input  logic [ID_WIDTH-1:0]        b_id_i,
  input  logic [1:0]                 b_resp_i,
  output logic [(1<<ID_WIDTH)-1:0]   pending_o,
  output logic                       done_valid_o,
  output logic [ID_WIDTH-1:0]        done_id_o,
  output logic                       done_error_o
);

  localparam int unsigned ID_NUM = 1 << ID_WIDTH;

  logic [ID_NUM-1:0]   pending_q, pending_d;
  logic                done_valid_q;
  logic [ID_WIDTH-1:0] done_id_q;
  logic                done_error_q;
  logic                b_hit;

  // A B response only counts when its ID is actually outstanding.
  assign b_hit = b_valid_i && pending_q[b_id_i];

  always_comb begin
    pending_d = pending_q;
    if (b_hit) pending_d[b_id_i] = 1'b0;
    if (set_i) pending_d[set_id_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q    <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_error_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      done_valid_q <= b_hit;
      done_error_q <= b_hit && (b_resp_i != RESP_OKAY);
      if (b_hit) done_id_q <= b_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && b_valid_i && !pending_q[b_id_i])
      $warning("B response for idle write id %0d ignored", b_id_i);
  end

  assign pending_o    = pending_q;
  assign done_valid_o = done_valid_q;
  assign done_id_o    = done_id_q;
  assign done_error_o = done_error_q;

endmodule

// File: rtl/memory_write_channel_scheduler.sv
// Drives AW/W bursts for the write-queue head entry and gates slot reuse on B responses.
module memory_write_channel_scheduler
  import memory_write_channel_scheduler_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = MWCS_ID_WIDTH,
  parameter int unsigned ADDR_WIDTH = MWCS_ADDR_WIDTH,
  parameter int unsigned ENTRY_BITS = MWCS_ENTRY_BITS,
  parameter int unsigned DATA_WIDTH = MWCS_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  req_ready_o,
  output logic                  q_push_o,
  output logic                  q_pop_o,
  input  logic                  q_full_i,
  input  logic                  q_empty_i,
  input  logic [ID_WIDTH-1:0]   q_head_ptr_i,
  input  logic [ID_WIDTH-1:0]   q_tail_ptr_i,
  input  logic [ENTRY_BITS-1:0] q_head_data_i,
  output logic                  aw_valid_o,
  input  logic                  aw_ready_i,
  output logic [ID_WIDTH-1:0]   aw_id_o,
  output logic [ADDR_WIDTH-1:0] aw_addr_o,
  output logic [7:0]            aw_len_o,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  output logic [DATA_WIDTH-1:0] w_data_o,
  output logic                  w_last_o,
  input  logic                  b_valid_i,
  input  logic [ID_WIDTH-1:0]   b_id_i,
  input  logic [1:0]            b_resp_i,
  output logic                  done_valid_o,
  output logic [ID_WIDTH-1:0]   done_id_o,
  output logic                  done_error_o,
  output logic                  busy_o
);

  localparam int unsigned ID_NUM = 1 << ID_WIDTH;
  localparam int unsigned BEATS  = ENTRY_BITS / DATA_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  w_beat_state_e         w_state_q, w_state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  aw_sent_q, aw_sent_d;
  logic [ADDR_WIDTH-1:0] addr_table_q [ID_NUM];
  logic [DATA_WIDTH-1:0] beat_words [BEATS];
  logic [ID_NUM-1:0]     pending;

  logic req_ready, q_push, q_pop;
  logic aw_valid, w_valid, aw_hs, w_hs, w_last, aw_done;

  // Every handshake is suppressed while reset is asserted.
  assign req_ready = rst_ni && !q_full_i && !pending[q_tail_ptr_i];
  assign q_push    = req_valid_i && req_ready;
  assign aw_valid  = rst_ni && !q_empty_i && !aw_sent_q;
  assign w_valid   = rst_ni && !q_empty_i && (w_state_q != W_WAIT_AW);
  assign w_last    = (beat_q == LAST_BEAT);
  assign aw_hs     = aw_valid && aw_ready_i;
  assign w_hs      = w_valid && w_ready_i;
  assign aw_done   = aw_sent_q || aw_hs;
  assign q_pop     = (w_hs && w_last && aw_done) || ((w_state_q == W_WAIT_AW) && aw_hs);

  for (genvar g = 0; g < BEATS; g++) begin : g_beat
    assign beat_words[g] = q_head_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    w_state_d = w_state_q;
    beat_d    = beat_q;
    aw_sent_d = aw_sent_q;
    if (aw_hs) aw_sent_d = 1'b1;
    if (q_pop) aw_sent_d = 1'b0;
    case (w_state_q)
      W_IDLE, W_BURST: begin
        if (w_hs) begin
          if (w_last) begin
            beat_d    = '0;
            w_state_d = aw_done ? W_IDLE : W_WAIT_AW;
          end else begin
            beat_d    = beat_q + 1'b1;
            w_state_d = W_BURST;
          end
        end
      end
      W_WAIT_AW: if (aw_hs) w_state_d = W_IDLE;
      default:   w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      beat_q    <= '0;
      aw_sent_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      beat_q    <= beat_d;
      aw_sent_q <= aw_sent_d;
    end
  end

  // Address side-table: written at the tail, read at the head, no reset needed.
  always_ff @(posedge clk_i) begin
    if (q_push) addr_table_q[q_tail_ptr_i] <= req_addr_i;
  end

  memory_write_channel_scheduler_id_tracker #(
    .ID_WIDTH (ID_WIDTH)
  ) u_id_tracker (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .set_i        (q_pop),
    .set_id_i     (q_head_ptr_i),
    .b_valid_i    (b_valid_i),
    .b_id_i       (b_id_i),
    .b_resp_i     (b_resp_i),
    .pending_o    (pending),
    .done_valid_o (done_valid_o),
    .done_id_o    (done_id_o),
    .done_error_o (done_error_o)
  );

  assign req_ready_o = req_ready;
  assign q_push_o    = q_push;
  assign q_pop_o     = q_pop;
  assign aw_valid_o  = aw_valid;
  assign aw_id_o     = q_head_ptr_i;
  assign aw_addr_o   = addr_table_q[q_head_ptr_i];
  assign aw_len_o    = 8'(BEATS - 1);
  assign w_valid_o   = w_valid;
  assign w_data_o    = beat_words[beat_q];
  assign w_last_o    = w_last;
  assign busy_o      = !q_empty_i || (|pending);

endmodule

// File: tb/tb_memory_write_channel_scheduler.sv
// Directed bench for the write-channel scheduler with a behavioural write-queue model.
module tb_memory_write_channel_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic [127:0] req_data;
  logic         aw_ready, w_ready, b_valid;
  logic [2:0]   b_id;
  logic [1:0]   b_resp;

  logic         req_ready, q_push, q_pop;
  logic         aw_valid, w_valid, w_last;
  logic [2:0]   aw_id;
  logic [31:0]  aw_addr;
  logic [7:0]   aw_len;
  logic [31:0]  w_data;
  logic         done_valid, done_error, busy;
  logic [2:0]   done_id;

  // Queue model: 8 slots, slot index is the write ID.
  logic [127:0] qmem [8];
  logic [2:0]   q_head, q_tail;
  logic [3:0]   q_cnt;
  logic         q_full, q_empty;
  logic [127:0] q_head_data;

  assign q_full      = (q_cnt == 4'd8);
  assign q_empty     = (q_cnt == 4'd0);
  assign q_head_data = qmem[q_head];

  always @(posedge clk) begin
    if (!rst_n) begin
      q_head <= 3'd0;
      q_tail <= 3'd0;
      q_cnt  <= 4'd0;
    end else begin
      if (q_push) begin
        qmem[q_tail] <= req_data;
        q_tail       <= q_tail + 3'd1;
      end
      if (q_pop) q_head <= q_head + 3'd1;
      q_cnt <= q_cnt + 4'(q_push) - 4'(q_pop);
    end
  end

  memory_write_channel_scheduler dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_addr_i    (req_addr),
    .req_ready_o   (req_ready),
    .q_push_o      (q_push),
    .q_pop_o       (q_pop),
    .q_full_i      (q_full),
    .q_empty_i     (q_empty),
    .q_head_ptr_i  (q_head),
    .q_tail_ptr_i  (q_tail),
    .q_head_data_i (q_head_data),
    .aw_valid_o    (aw_valid),
    .aw_ready_i    (aw_ready),
    .aw_id_o       (aw_id),
    .aw_addr_o     (aw_addr),
    .aw_len_o      (aw_len),
    .w_valid_o     (w_valid),
    .w_ready_i     (w_ready),
    .w_data_o      (w_data),
    .w_last_o      (w_last),
    .b_valid_i     (b_valid),
    .b_id_i        (b_id),
    .b_resp_i      (b_resp),
    .done_valid_o  (done_valid),
    .done_id_o     (done_id),
    .done_error_o  (done_error),
    .busy_o        (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_data  = 128'h0;
    aw_ready  = 1'b1;
    w_ready   = 1'b1;
    b_valid   = 1'b0;
    b_id      = 3'd0;
    b_resp    = 2'd0;

    // Reset state
    nxt(); #1;
    chk("rst_aw_valid",   128'(aw_valid),   128'h0);
    chk("rst_w_valid",    128'(w_valid),    128'h0);
    chk("rst_q_pop",      128'(q_pop),      128'h0);
    chk("rst_q_push",     128'(q_push),     128'h0);
    chk("rst_done_valid", 128'(done_valid), 128'h0);
    chk("rst_done_error", 128'(done_error), 128'h0);
    chk("rst_busy",       128'(busy),       128'h0);
    nxt();
    rst_n = 1'b1;

    // 1: single zero-stall write, id0
    nxt();
    req_valid = 1'b1; req_addr = 32'h1000;
    req_data  = 128'h44444444_33333333_22222222_11111111;
    #1;
    chk("t1_req_ready", 128'(req_ready), 128'h1);
    chk("t1_q_push",    128'(q_push),    128'h1);
    chk("t1_aw_early",  128'(aw_valid),  128'h0);
    nxt();
    req_valid = 1'b0; #1;
    chk("t1_aw_valid", 128'(aw_valid), 128'h1);
    chk("t1_aw_id",    128'(aw_id),    128'h0);
    chk("t1_aw_addr",  128'(aw_addr),  128'h1000);
    chk("t1_aw_len",   128'(aw_len),   128'h3);
    chk("t1_w_valid",  128'(w_valid),  128'h1);
    chk("t1_beat0",    128'(w_data),   128'h11111111);
    chk("t1_last0",    128'(w_last),   128'h0);
    chk("t1_busy",     128'(busy),     128'h1);
    nxt(); #1;
    chk("t1_aw_sent", 128'(aw_valid), 128'h0);
    chk("t1_beat1",   128'(w_data),   128'h22222222);
    nxt(); #1;
    chk("t1_beat2",   128'(w_data),   128'h33333333);
    chk("t1_nopop2",  128'(q_pop),    128'h0);
    nxt(); #1;
    chk("t1_beat3",   128'(w_data),   128'h44444444);
    chk("t1_last3",   128'(w_last),   128'h1);
    chk("t1_pop",     128'(q_pop),    128'h1);
    nxt();
    b_valid = 1'b1; b_id = 3'd0; b_resp = 2'd0; #1;
    chk("t1_idle_w",   128'(w_valid),    128'h0);
    chk("t1_busy_b",   128'(busy),       128'h1);
    chk("t1_no_done",  128'(done_valid), 128'h0);
    nxt();
    b_valid = 1'b0; #1;
    chk("t1_done",     128'(done_valid), 128'h1);
    chk("t1_done_id",  128'(done_id),    128'h0);
    chk("t1_done_err", 128'(done_error), 128'h0);
    chk("t1_idle",     128'(busy),       128'h0);
    nxt(); #1;
    chk("t1_done_off", 128'(done_valid), 128'h0);

    // 2: AW stalled until after wLast, W always ready, id1
    nxt();
    aw_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h2000;
    req_data = 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000;
    #1;
    chk("t2_req_ready", 128'(req_ready), 128'h1);
    nxt();
    req_valid = 1'b0; #1;
    chk("t2_aw_valid", 128'(aw_valid), 128'h1);
    chk("t2_aw_id",    128'(aw_id),    128'h1);
    chk("t2_aw_addr",  128'(aw_addr),  128'h2000);
    chk("t2_beat0",    128'(w_data),   128'hEEEE0000);
    nxt(); nxt(); nxt(); #1;
    chk("t2_beat3",    128'(w_data),   128'hEEEE0003);
    chk("t2_last",     128'(w_last),   128'h1);
    chk("t2_nopop",    128'(q_pop),    128'h0);
    nxt(); #1;
    chk("t2_wait_w",   128'(w_valid),  128'h0);
    chk("t2_wait_aw",  128'(aw_valid), 128'h1);
    chk("t2_wait_pop", 128'(q_pop),    128'h0);
    nxt();
    aw_ready = 1'b1; #1;
    chk("t2_pop",      128'(q_pop),    128'h1);
    chk("t2_pop_w",    128'(w_valid),  128'h0);
    nxt();
    b_valid = 1'b1; b_id = 3'd1; b_resp = 2'd0; #1;
    chk("t2_aw_clear", 128'(aw_valid), 128'h0);
    chk("t2_busy",     128'(busy),     128'h1);
    nxt();
    b_valid = 1'b0; #1;
    chk("t2_done_id",  128'(done_id),    128'h1);
    chk("t2_done",     128'(done_valid), 128'h1);

    // 3: fill all eight slots (ids 2..7,0,1) with B withheld
    nxt();
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1;
      req_addr  = 32'h3000 + 32'(k * 64);
      for (int b = 0; b < 4; b++) req_data[b*32 +: 32] = 32'(k * 16 + b);
      #1;
      chk($sformatf("t3_accept%0d", k), 128'(req_ready), 128'h1);
      nxt();
    end
    req_valid = 1'b0;
    repeat (21) nxt();
    #1;
    chk("t3_last_aw_id",   128'(aw_id),    128'h1);
    chk("t3_last_aw_addr", 128'(aw_addr),  128'h31C0);
    chk("t3_last_beat0",   128'(w_data),   128'h70);
    repeat (4) nxt();
    #1;
    chk("t3_drained_aw", 128'(aw_valid),  128'h0);
    chk("t3_blocked",    128'(req_ready), 128'h0);
    chk("t3_busy",       128'(busy),      128'h1);
    b_valid = 1'b1; b_id = 3'd2; b_resp = 2'd0; #1;
    chk("t3_blocked_b",  128'(req_ready), 128'h0);
    nxt();
    b_valid = 1'b0; #1;
    chk("t3_reuse",      128'(req_ready), 128'h1);
    chk("t3_done_id2",   128'(done_id),   128'h2);

    // 4/5: refill slot 2, then B responses 4,5,6,7,3,1(SLVERR),0,2 and a spurious id5
    req_valid = 1'b1; req_addr = 32'h5000;
    req_data  = 128'h55550003_55550002_55550001_55550000;
    #1;
    chk("t4_push", 128'(q_push), 128'h1);
    nxt();
    req_valid = 1'b0; b_valid = 1'b1; b_id = 3'd4; #1;
    chk("t4_aw_id",   128'(aw_id),   128'h2);
    chk("t4_aw_addr", 128'(aw_addr), 128'h5000);
    nxt();
    b_id = 3'd5; #1;
    chk("t4_done4", 128'(done_id), 128'h4);
    nxt();
    b_id = 3'd6; #1;
    chk("t4_done5", 128'(done_id), 128'h5);
    nxt();
    b_id = 3'd7; #1;
    chk("t4_done6",    128'(done_id), 128'h6);
    chk("t4_pop_id2",  128'(q_pop),   128'h1);
    nxt();
    b_id = 3'd3; #1;
    chk("t4_done7",    128'(done_id),    128'h7);
    chk("t4_done7_v",  128'(done_valid), 128'h1);
    nxt();
    b_id = 3'd1; b_resp = 2'b10; #1;
    chk("t4_done3",     128'(done_id),    128'h3);
    chk("t4_done3_err", 128'(done_error), 128'h0);
    nxt();
    b_id = 3'd0; b_resp = 2'b00; #1;
    chk("t5_done1",     128'(done_id),    128'h1);
    chk("t5_done1_err", 128'(done_error), 128'h1);
    nxt();
    b_id = 3'd2; #1;
    chk("t4_done0",      128'(done_id),    128'h0);
    chk("t4_busy_last",  128'(busy),       128'h1);
    nxt();
    b_id = 3'd5; #1;
    chk("t4_done2",      128'(done_id),    128'h2);
    chk("t4_done2_v",    128'(done_valid), 128'h1);
    chk("t4_busy_low",   128'(busy),       128'h0);
    nxt();
    b_valid = 1'b0; #1;
    chk("t5_spurious",   128'(done_valid), 128'h0);
    chk("t5_still_idle", 128'(busy),       128'h0);

    // 6: reset in the middle of a burst, then a fresh write from id0
    nxt();
    req_valid = 1'b1; req_addr = 32'h6000;
    req_data  = 128'h66660003_66660002_66660001_66660000;
    #1;
    chk("t6_req_ready", 128'(req_ready), 128'h1);
    nxt();
    req_valid = 1'b0; #1;
    chk("t6_aw_id", 128'(aw_id),  128'h3);
    chk("t6_beat0", 128'(w_data), 128'h66660000);
    nxt(); nxt();
    rst_n = 1'b0; #1;
    chk("t6_beat2", 128'(w_data), 128'h66660002);
    nxt(); #1;
    chk("t6_rst_aw",   128'(aw_valid),   128'h0);
    chk("t6_rst_w",    128'(w_valid),    128'h0);
    chk("t6_rst_pop",  128'(q_pop),      128'h0);
    chk("t6_rst_done", 128'(done_valid), 128'h0);
    chk("t6_rst_busy", 128'(busy),       128'h0);
    rst_n = 1'b1;
    nxt();
    req_valid = 1'b1; req_addr = 32'h7000;
    req_data  = 128'h77770003_77770002_77770001_77770000;
    #1;
    chk("t6_fresh_ready", 128'(req_ready), 128'h1);
    nxt();
    req_valid = 1'b0; #1;
    chk("t6_fresh_aw",    128'(aw_valid), 128'h1);
    chk("t6_fresh_id",    128'(aw_id),    128'h0);
    chk("t6_fresh_addr",  128'(aw_addr),  128'h7000);
    chk("t6_fresh_beat0", 128'(w_data),   128'h77770000);
    chk("t6_fresh_last0", 128'(w_last),   128'h0);
    nxt(); nxt(); nxt(); #1;
    chk("t6_fresh_pop",   128'(q_pop),    128'h1);
    nxt();
    b_valid = 1'b1; b_id = 3'd0; b_resp = 2'd0;
    nxt();
    b_valid = 1'b0; #1;
    chk("t6_fresh_done",  128'(done_valid), 128'h1);
    chk("t6_fresh_did",   128'(done_id),    128'h0);
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
